// File: rtl/encrypted_serializer.sv
// Round-robin collector for the encrypter bank: captures one ciphertext packet per lane in
// dispatch order and streams it MSB-nibble-first over a 4-bit valid/ready output.
module encrypted_serializer #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32,
  parameter int NUM_ENC_REG     = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_data,
  input  logic [NUM_ENCRYPTERS-1:0]             enc_valid,
  output logic [NUM_ENCRYPTERS-1:0]             enc_ack,
  output logic [3:0]                            out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  input  logic                                  restart,
  output logic [1:0]                            state_out,
  output logic [NUM_ENC_REG-1:0]                lane_out,
  output logic [CNT_WIDTH-1:0]                  packets_out
);

  localparam int W       = ENCRYPTER_WIDTH;
  localparam int N       = NUM_ENCRYPTERS;
  localparam int NIBBLES = W / 4;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NIB_W-1:0]       LAST_NIB = NIB_W'(NIBBLES - 1);
  localparam logic [NUM_ENC_REG-1:0] LAST_LANE = NUM_ENC_REG'(N - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [NUM_ENC_REG-1:0] lane_r, lane_s, lane_out_r;
  logic [W-1:0]           shift_r, shift_s, shift_nx_s, lane_data_s;
  logic [NIB_W-1:0]       nib_r, nib_s;
  logic [N-1:0]           ack_r, ack_s, lane_onehot_s;
  logic                   out_valid_r, out_valid_s, lane_valid_s;
  logic [3:0]             out_data_r, out_data_s;
  logic [CNT_WIDTH-1:0]   packets_r, packets_s;
  logic [1:0]             state_out_r;

  // Select the slice, valid bit and ack position of the lane currently expected.
  always_comb begin
    lane_data_s   = {W{1'b0}};
    lane_valid_s  = 1'b0;
    lane_onehot_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (lane_r == NUM_ENC_REG'(k)) begin
        lane_data_s      = enc_data[k*W +: W];
        lane_valid_s     = enc_valid[k];
        lane_onehot_s[k] = 1'b1;
      end else begin
        lane_onehot_s[k] = 1'b0;
      end
    end
  end

  assign shift_nx_s = shift_r << 4;

  // Next-state and datapath decode; every register holds unless a branch says otherwise.
  always_comb begin
    state_s     = state_r;
    lane_s      = lane_r;
    shift_s     = shift_r;
    nib_s       = nib_r;
    ack_s       = {N{1'b0}};
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    packets_s   = packets_r;
    case (state_r)
      ST_WAIT: begin
        out_valid_s = 1'b0;
        // A restart realigns the stream and suppresses capture in the same cycle.
        if (restart) begin
          lane_s = {NUM_ENC_REG{1'b0}};
        end else if (lane_valid_s) begin
          shift_s = lane_data_s;
          ack_s   = lane_onehot_s;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_LOAD: begin
        out_valid_s = 1'b1;
        out_data_s  = shift_r[W-1 -: 4];
        nib_s       = {NIB_W{1'b0}};
        state_s     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (out_valid_r && out_ready) begin
          if (nib_r == LAST_NIB) begin
            out_valid_s = 1'b0;
            out_data_s  = 4'h0;
            shift_s     = {W{1'b0}};
            nib_s       = {NIB_W{1'b0}};
            packets_s   = packets_r + CNT_WIDTH'(1);
            lane_s      = (lane_r == LAST_LANE) ? {NUM_ENC_REG{1'b0}} : lane_r + NUM_ENC_REG'(1);
            state_s     = ST_WAIT;
          end else begin
            shift_s    = shift_nx_s;
            out_data_s = shift_nx_s[W-1 -: 4];
            nib_s      = nib_r + NIB_W'(1);
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s     = ST_WAIT;
        out_valid_s = 1'b0;
        out_data_s  = 4'h0;
      end
    endcase
  end

  // State and datapath registers; reset discards any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_WAIT;
      lane_r      <= {NUM_ENC_REG{1'b0}};
      shift_r     <= {W{1'b0}};
      nib_r       <= {NIB_W{1'b0}};
      ack_r       <= {N{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 4'h0;
      packets_r   <= {CNT_WIDTH{1'b0}};
      state_out_r <= 2'd0;
      lane_out_r  <= {NUM_ENC_REG{1'b0}};
    end else begin
      state_r     <= state_s;
      lane_r      <= lane_s;
      shift_r     <= shift_s;
      nib_r       <= nib_s;
      ack_r       <= ack_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      packets_r   <= packets_s;
      state_out_r <= state_s;
      lane_out_r  <= lane_s;
    end
  end

  assign enc_ack     = ack_r;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign state_out   = state_out_r;
  assign lane_out    = lane_out_r;
  assign packets_out = packets_r;

endmodule

// File: tb/tb_encrypted_serializer.sv
// Directed bench for encrypted_serializer: ordering, backpressure, restart and reset behaviour.
module tb_encrypted_serializer;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int CW = 16;

  logic            clk;
  logic            reset;
  logic [N*W-1:0]  enc_data;
  logic [N-1:0]    enc_valid;
  logic [N-1:0]    enc_ack;
  logic [3:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            restart;
  logic [1:0]      state_out;
  logic [NR-1:0]   lane_out;
  logic [CW-1:0]   packets_out;

  int n_checks = 0;
  int n_pass   = 0;

  encrypted_serializer #(
    .NUM_ENCRYPTERS(N), .ENCRYPTER_WIDTH(W), .NUM_ENC_REG(NR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .enc_data(enc_data), .enc_valid(enc_valid), .enc_ack(enc_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .restart(restart),
    .state_out(state_out), .lane_out(lane_out), .packets_out(packets_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for the ack on lane ln, then drains all nibbles; bp applies ready pattern 1,0,0,...
  task automatic run_packet(input int ln, input logic [31:0] pkt, input bit bp);
    int waitc;
    int idx;
    int cyc;
    logic [3:0] exp_ack;
    waitc = 0;
    while (enc_ack == 4'b0000 && waitc < 20) begin
      step();
      waitc++;
    end
    exp_ack = 4'b0001 << ln;
    check("ack_lane", enc_ack, exp_ack);
    check("ack_state_load", state_out, 2'd1);
    enc_valid[ln] = 1'b0;
    step();
    check("ack_one_cycle", enc_ack, 4'b0000);
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      check("nib_valid", out_valid, 1'b1);
      check("nib_data", out_data, pkt[31-4*idx -: 4]);
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (out_ready) idx++;
      cyc++;
      step();
    end
    check("gap_after_packet", out_valid, 1'b0);
    out_ready = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    enc_data  = '0;
    enc_valid = 4'b0000;
    out_ready = 1'b1;
    restart   = 1'b0;

    // 1: reset state, then idle after release
    repeat (3) step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 4'h0);
    check("rst_ack", enc_ack, 4'b0000);
    check("rst_state", state_out, 2'd0);
    check("rst_lane", lane_out, 2'd0);
    check("rst_packets", packets_out, 16'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_valid", out_valid, 1'b0);
      check("idle_state", state_out, 2'd0);
    end

    // 2: single packet on lane 0
    enc_data[0*W +: W] = 32'hDEADBEEF;
    enc_valid = 4'b0001;
    run_packet(0, 32'hDEADBEEF, 1'b0);
    check("single_packets", packets_out, 16'd1);
    check("single_lane", lane_out, 2'd1);
    check("single_state", state_out, 2'd0);

    // 3: realign, then all lanes valid together are served in order
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_lane0", lane_out, 2'd0);
    enc_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    enc_valid = 4'b1111;
    run_packet(0, 32'h11111111, 1'b0);
    run_packet(1, 32'h22222222, 1'b0);
    run_packet(2, 32'h33333333, 1'b0);
    run_packet(3, 32'h44444444, 1'b0);
    check("order_packets", packets_out, 16'd5);
    check("order_lane_wrap", lane_out, 2'd0);

    // 4: lane 2 ready early is held until lanes 0 and 1 are served
    enc_data[0*W +: W] = 32'hA5A50F0F;
    enc_data[1*W +: W] = 32'h01234567;
    enc_data[2*W +: W] = 32'hCAFEF00D;
    enc_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      check("ooo_no_ack", enc_ack, 4'b0000);
      check("ooo_no_valid", out_valid, 1'b0);
    end
    enc_valid[0] = 1'b1;
    run_packet(0, 32'hA5A50F0F, 1'b0);
    enc_valid[1] = 1'b1;
    run_packet(1, 32'h01234567, 1'b0);
    // 5: backpressure on lane 2's packet
    run_packet(2, 32'hCAFEF00D, 1'b1);
    check("ooo_packets", packets_out, 16'd8);
    check("ooo_lane", lane_out, 2'd3);

    // 6: restart at lane 3, then async reset during the fourth nibble
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_from3", lane_out, 2'd0);
    enc_data[0*W +: W] = 32'h12345678;
    enc_valid = 4'b0001;
    step();
    check("r6_ack", enc_ack, 4'b0001);
    enc_valid = 4'b0000;
    step();
    repeat (3) step();
    check("r6_nib3", out_data, 4'h4);
    check("r6_state_shift", state_out, 2'd2);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_lane", lane_out, 2'd0);
    check("arst_packets", packets_out, 16'd0);
    check("arst_state", state_out, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_ack", enc_ack, 4'b0000);
      check("post_rst_valid", out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
